uart_rx_os: RTL

Parametrised UART receiver that replaces the one-sample-per-bit receiver. It counts an oversampling tick, samples each bit at mid-bit, and rejects start-bit glitches. Data width and stop-bit count are configurable, framing errors and line breaks are detected, and even/odd parity checking is optional. It sits between the pad-side rx line and the UART RX FIFO / bus interface, driven by the shared baud-tick generator.

---
 rtl/uart_rx_os_if.sv | 23 ++
 rtl/uart_rx_os.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os_if.sv
// Receiver-side bundle between the pad/baud-tick sources and the RX FIFO.
// master: the receiver; slave: whatever feeds the line and consumes frames.
interface uart_rx_os_if #(
    parameter int unsigned DataWidth = 8
);
    logic                 tick_i;
    logic                 rx_i;
    logic                 rx_dv_o;
    logic [DataWidth-1:0] data_o;
    logic                 frame_err_o;
    logic                 parity_err_o;
    logic                 busy_o;

    modport master (
        input  tick_i, rx_i,
        output rx_dv_o, data_o, frame_err_o, parity_err_o, busy_o
    );

    modport slave (
        output tick_i, rx_i,
        input  rx_dv_o, data_o, frame_err_o, parity_err_o, busy_o
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, start-glitch rejection, break resync.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_os #(
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned Oversample = 16,
    parameter int unsigned StopBits   = 1,
    parameter int unsigned ParityOdd  = 0
) (
    input logic          clk_i,
    input logic          rst_i,
    uart_rx_os_if.master bus
);
    localparam int unsigned SW = $clog2(Oversample);
    localparam int unsigned BW = $clog2(DataWidth + 1);
    localparam logic [SW-1:0] SMid      = SW'(Oversample / 2 - 1);
    localparam logic [SW-1:0] SEnd      = SW'(Oversample - 1);
    localparam logic [BW-1:0] BLastData = BW'(DataWidth - 1);
    localparam logic [BW-1:0] BLastStop = BW'(StopBits - 1);

    if (DataWidth < 5 || DataWidth > 9 || Oversample < 4 || (Oversample % 2) != 0 ||
        StopBits < 1 || StopBits > 2 || ParityOdd > 1) begin : g_bad_cfg
        $error("uart_rx_os: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StResync
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rxd_q;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [BW-1:0]        b_cnt_q, b_cnt_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 ferr_q, ferr_d, ferr_now;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_dv_q, rx_dv_d;
`ifdef UART_RX_PARITY_EN
    localparam logic POdd = (ParityOdd != 0);
    logic                 par_q, par_d;
    logic                 parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q    <= 1'b1;
            rxd_q        <= 1'b1;
            state_q      <= StIdle;
            s_cnt_q      <= '0;
            b_cnt_q      <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            ferr_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_dv_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= bus.rx_i;
            rxd_q        <= rx_meta_q;
            state_q      <= state_d;
            s_cnt_q      <= s_cnt_d;
            b_cnt_q      <= b_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            ferr_q       <= ferr_d;
            frame_err_q  <= frame_err_d;
            rx_dv_q      <= rx_dv_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        b_cnt_d     = b_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ferr_d      = ferr_q;
        frame_err_d = frame_err_q;
        rx_dv_d     = 1'b0;
        ferr_now    = ferr_q | ~rxd_q;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = parity_err_q;
`endif
        if (bus.tick_i) begin
            unique case (state_q)
                StIdle: begin
                    if (!rxd_q) begin
                        state_d = StStart;
                        s_cnt_d = '0;
                    end
                end
                StStart: begin
                    // Line back high at the start-bit centre means it was a glitch.
                    if (s_cnt_q == SMid) begin
                        s_cnt_d = '0;
                        b_cnt_d = '0;
                        state_d = rxd_q ? StIdle : StData;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (s_cnt_q == SEnd) begin
                        s_cnt_d = '0;
                        shift_d = {rxd_q, shift_q[DataWidth-1:1]};
                        b_cnt_d = b_cnt_q + 1'b1;
                        if (b_cnt_q == BLastData) begin
                            b_cnt_d = '0;
                            ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (s_cnt_q == SEnd) begin
                        s_cnt_d = '0;
                        par_d   = rxd_q;
                        state_d = StStop;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (s_cnt_q == SEnd) begin
                        s_cnt_d = '0;
                        b_cnt_d = b_cnt_q + 1'b1;
                        ferr_d  = ferr_now;
                        if (b_cnt_q == BLastStop) begin
                            b_cnt_d     = '0;
                            ferr_d      = 1'b0;
                            data_d      = shift_q;
                            frame_err_d = ferr_now;
                            rx_dv_d     = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = ((^shift_q) ^ par_q) != POdd;
`endif
                            state_d = ferr_now ? StResync : StIdle;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
                StResync: begin
                    if (rxd_q) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.rx_dv_o     = rx_dv_q;
    assign bus.data_o      = data_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.busy_o      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err_o = parity_err_q;
`else
    assign bus.parity_err_o = 1'b0;
`endif
endmodule
